procesador_rom: RTL
===================

# procesador_rom

Sequencer and arithmetic stage that sits directly around the 16×8 `memoria` ROM. On a start request it walks the ROM address range, reads one byte per cycle, and computes four statistics in parallel: sum, maximum, minimum and XOR checksum. The selected result is shown as hexadecimal on a 4-digit multiplexed 7-segment display. It drives the ROM `address` input and consumes its `data` output.

## Interface
- `DEPTH`, default 8: number of consecutive ROM entries scanned, from address 0. Legal range 1..16.
- `REFRESH_DIV`, default 50000: clock cycles each display digit stays lit. Must be ≥2.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: scan request. Rising-edge detected internally, so a held level triggers only once.
- `modo` in 2: display select. 0 = sum, 1 = max, 2 = min, 3 = XOR.
- `rom_addr` out 4: address to the ROM `address` port.
- `rom_data` in 8: combinational data from the ROM `data` port.
- `busy` out 1: high while scanning.
- `listo` out 1: high from scan completion until the next accepted start.
- `an` out 4: digit anodes, active-low, one-hot. `an[0]` is the least-significant digit.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- FSM states are `IDLE`, `SCAN` and `FIN`.
- `IDLE`:
  - On a `start` rising edge (previous-cycle register = 0, current = 1), go to `SCAN`.
  - On entry to `SCAN`: `rom_addr`←0, `suma`←0, `maximo`←0x00, `minimo`←0xFF, `xorv`←0x00, `listo`←0.
- `SCAN`, on each cycle:
  - Sample `rom_data` for the current `rom_addr` (combinational ROM, same-cycle valid).
  - Update accumulators: `suma`+=data, `maximo`=max, `minimo`=min, `xorv`^=data.
  - If `rom_addr`==DEPTH-1, go to `FIN`; otherwise increment `rom_addr`.
- `FIN`: latch the four results into display registers, set `listo`=1, and return to `IDLE`. `rom_addr` holds DEPTH-1.
- Arithmetic:
  - `suma` is 12 bits unsigned; no overflow is possible at DEPTH≤16 (16×255=4080).
  - `maximo`, `minimo` and `xorv` are 8 bits, zero-extended to 16 bits for display.
  - `suma` is zero-extended to 16 bits.
- `start` edges in `SCAN` or `FIN` are ignored and are not queued.
- `modo` is combinational into the display mux. It may change at any time, and the displayed value changes on the next digit refresh.
- Display refresh:
  - `cnt_ref` counts 0..REFRESH_DIV-1. On wrap, `digito` advances 0→1→2→3→0.
  - `an` = ~(1<<digito).
  - `seg` decodes nibble[digito] of the selected 16-bit value, using hex 0–F glyphs. Examples: 0 = 7'b1000000, 8 = 7'b0000000, F = 7'b0001110.
- Display registers update only in `FIN`, so the display shows the previous results throughout a scan.

## Timing
- Reset values:
  - State `IDLE`; `rom_addr`=0, `busy`=0, `listo`=0.
  - All accumulators and display registers 0; `cnt_ref`=0, `digito`=0.
  - `an`=4'b1110, `seg`=7'b1000000 (shows "0000").
- Latency: start edge sampled at edge E. `busy` is high from E+1 through E+DEPTH. `listo` is 1 and results are valid from E+DEPTH+1.
- `busy`=1 exactly in `SCAN`. Total scan length is DEPTH cycles.
- Reset mid-scan returns to reset values immediately; partial results are discarded.
- DEPTH=1: `SCAN` lasts one cycle, and all four results derive from entry 0.

## Configuration
- `LEADING_ZERO_BLANK_EN`:
  - When defined, a digit whose nibble and all higher nibbles are zero has its anode held high (off), except digit 0, which always lights.
  - When undefined, all four digits always light, including leading zeros.

## Test plan
- Reset: assert `rst` mid-refresh → `an`=4'b1110, `seg`=7'b1000000, `busy`=0, `listo`=0, `rom_addr`=0 asynchronously.
- ROM 0x01..0x08, DEPTH=8, `start` pulse → `busy` high exactly 8 cycles, `rom_addr` steps 0..7, then `listo`=1. Expected results:
  - `modo`=0 → 0x0024
  - `modo`=1 → 0x0008
  - `modo`=2 → 0x0001
  - `modo`=3 → 0x0008
- ROM all 0xFF, DEPTH=16 (ROM 16 deep) → sum 0x0FF0, max 0x00FF, min 0x00FF, xor 0x0000.
- `start` held high for 20 cycles, with a second pulse issued mid-scan → exactly one scan, and results match the single-scan case.
- Reset asserted at `rom_addr`=3, then a new start → results from a fresh scan only, with no carry-over in the sum.
- REFRESH_DIV=4, sum 0x0024 → `an` cycles 1110,1101,1011,0111 every 4 cycles; `seg` shows 4,2,0,0. With `LEADING_ZERO_BLANK_EN`, digits 2 and 3 are off (`an` bit high).

Source files
------------

// File: rtl/procesador_rom.sv
// ROM scan sequencer: sum/max/min/XOR over the first DEPTH ROM bytes, shown on a 4-digit 7-segment display.
// Build option: define LEADING_ZERO_BLANK_EN to switch off leading-zero digits (digit 0 always lit).
module procesador_rom #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] modo,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       busy,
    output logic       listo,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int unsigned CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [3:0]  LAST_ADDR = 4'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state_q;
    logic        start_q;
    logic [3:0]  rom_addr_q;
    logic        busy_q;
    logic        listo_q;
    logic [11:0] suma_q;
    logic [7:0]  maximo_q;
    logic [7:0]  minimo_q;
    logic [7:0]  xorv_q;
    logic [11:0] disp_suma_q;
    logic [7:0]  disp_max_q;
    logic [7:0]  disp_min_q;
    logic [7:0]  disp_xor_q;

    logic [CNT_W-1:0] cnt_ref_q;
    logic [1:0]       digito_q;
    logic [1:0]       digito_d;
    logic [3:0]       an_q;
    logic [3:0]       an_d;
    logic [6:0]       seg_q;
    logic [6:0]       seg_d;
    logic [15:0]      sel_c;
    logic [3:0]       nib_c;
    logic [3:0]       onehot_c;

    assign rom_addr = rom_addr_q;
    assign busy     = busy_q;
    assign listo    = listo_q;
    assign an       = an_q;
    assign seg      = seg_q;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Scan FSM: accumulators update in SCAN, results move to the display registers in FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            rom_addr_q  <= 4'd0;
            busy_q      <= 1'b0;
            listo_q     <= 1'b0;
            suma_q      <= 12'd0;
            maximo_q    <= 8'h00;
            minimo_q    <= 8'h00;
            xorv_q      <= 8'h00;
            disp_suma_q <= 12'd0;
            disp_max_q  <= 8'h00;
            disp_min_q  <= 8'h00;
            disp_xor_q  <= 8'h00;
        end else begin
            start_q <= start;
            case (state_q)
                IDLE: begin
                    if (start && !start_q) begin
                        state_q    <= SCAN;
                        rom_addr_q <= 4'd0;
                        busy_q     <= 1'b1;
                        listo_q    <= 1'b0;
                        suma_q     <= 12'd0;
                        maximo_q   <= 8'h00;
                        minimo_q   <= 8'hFF;
                        xorv_q     <= 8'h00;
                    end
                end
                SCAN: begin
                    suma_q <= suma_q + 12'(rom_data);
                    xorv_q <= xorv_q ^ rom_data;
                    if (rom_data > maximo_q) maximo_q <= rom_data;
                    if (rom_data < minimo_q) minimo_q <= rom_data;
                    if (rom_addr_q == LAST_ADDR) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                    end else begin
                        rom_addr_q <= rom_addr_q + 4'd1;
                    end
                end
                FIN: begin
                    disp_suma_q <= suma_q;
                    disp_max_q  <= maximo_q;
                    disp_min_q  <= minimo_q;
                    disp_xor_q  <= xorv_q;
                    listo_q     <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Display value select and next-digit decode, loaded into an/seg on each refresh wrap.
    always_comb begin
        sel_c = 16'(disp_suma_q);
        case (modo)
            2'd1:    sel_c = 16'(disp_max_q);
            2'd2:    sel_c = 16'(disp_min_q);
            2'd3:    sel_c = 16'(disp_xor_q);
            default: sel_c = 16'(disp_suma_q);
        endcase
    end

    assign digito_d = digito_q + 2'd1;
    assign onehot_c = 4'b0001 << digito_d;
    assign nib_c    = 4'(sel_c >> {digito_d, 2'b00});
    assign seg_d    = hex7(nib_c);

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] blank_c;
    assign blank_c = {sel_c[15:12] == 4'h0, sel_c[15:8] == 8'h00, sel_c[15:4] == 12'h000, 1'b0};
    assign an_d    = ~onehot_c | blank_c;
`else
    assign an_d    = ~onehot_c;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_ref_q <= '0;
            digito_q  <= 2'd0;
            an_q      <= 4'b1110;
            seg_q     <= 7'b1000000;
        end else if (cnt_ref_q == CNT_LAST) begin
            cnt_ref_q <= '0;
            digito_q  <= digito_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end else begin
            cnt_ref_q <= cnt_ref_q + CNT_W'(1);
        end
    end

endmodule
